// File: rtl/hex_digit_scanner.sv
// Time-multiplexed hex digit scanner: cycles through DIGITS nibbles with a SCAN_DIV dwell,
// latching new display values only at frame boundaries so a frame never mixes two values.
module hex_digit_scanner #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [4*DIGITS-1:0]   load_data,
  input  logic                  lz_en,
  output logic [3:0]            hex,
  output logic                  blank,
  output logic [DIGITS-1:0]     dig_an,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    div_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [4*DIGITS-1:0] disp_reg;
  logic [4*DIGITS-1:0] pend_data_reg;
  logic                pending_reg;
  logic                frame_done_reg;

  logic                div_last;
  logic                boundary;
  logic [3:0]          nib [DIGITS];
  logic [DIGITS-1:0]   nib_zero;
  logic [DIGITS-1:0]   upper_zero;

  assign div_last = (div_reg == DIV_LAST);
  assign boundary = div_last && (idx_reg == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg        <= '0;
      idx_reg        <= '0;
      disp_reg       <= '0;
      pend_data_reg  <= '0;
      pending_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= boundary;
      if (div_last) begin
        div_reg <= '0;
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end else begin
        div_reg <= div_reg + 1'b1;
      end
      // Apply and accept are mutually exclusive: ready is low whenever apply can happen.
      if (boundary && pending_reg) begin
        disp_reg    <= pend_data_reg;
        pending_reg <= 1'b0;
      end else if (load_valid && !pending_reg) begin
        pend_data_reg <= load_data;
        pending_reg   <= 1'b1;
      end
    end
  end

  // upper_zero[i]: nibbles i..DIGITS-1 of the displayed value are all zero.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign nib[gi]      = disp_reg[4*gi +: 4];
      assign nib_zero[gi] = (disp_reg[4*gi +: 4] == 4'h0);
      assign dig_an[gi]   = (idx_reg != IDX_W'(gi));
      if (gi == DIGITS - 1) begin : g_top
        assign upper_zero[gi] = nib_zero[gi];
      end else begin : g_chain
        assign upper_zero[gi] = nib_zero[gi] & upper_zero[gi+1];
      end
    end
  endgenerate

  assign hex        = nib[idx_reg];
  assign blank      = lz_en & (idx_reg != '0) & upper_zero[idx_reg];
  assign load_ready = ~pending_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Directed bench for hex_digit_scanner with DIGITS=4, SCAN_DIV=4.
module tb_hex_digit_scanner;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  hex;
  logic        blank;
  logic [3:0]  dig_an;
  logic        frame_done;

  int compared = 0;
  int mismatched = 0;

  hex_digit_scanner #(.DIGITS(4), .SCAN_DIV(4), .CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .lz_en      (lz_en),
    .hex        (hex),
    .blank      (blank),
    .dig_an     (dig_an),
    .frame_done (frame_done)
  );

  initial begin
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " dig_an"}, 16'(dig_an), 16'h000E);
    chk({tag, " hex"}, 16'(hex), 16'h0);
    chk({tag, " blank"}, 16'(blank), 16'h0);
    chk({tag, " load_ready"}, 16'(load_ready), 16'h1);
    chk({tag, " frame_done"}, 16'(frame_done), 16'h0);
  endtask

  // Offer a value for one edge; it must be taken (ready drops afterwards).
  task automatic load_one(input logic [15:0] v);
    load_valid = 1'b1;
    load_data  = v;
    @(negedge clk);
    chk("load taken", 16'(load_ready), 16'h0);
    load_valid = 1'b0;
    $display("load %04h offered at %0t", v, $time);
  endtask

  task automatic wait_boundary();
    bit found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (frame_done) found = 1'b1;
    end
    if (!found) begin
      compared++;
      mismatched++;
      $error("FAIL wait_boundary: observed no frame_done expected pulse within 40 cycles");
    end
  endtask

  // Starts on the cycle frame_done is high; checks one full frame and the next pulse.
  task automatic check_frame(input logic [15:0] v, input logic [3:0] blank_mask);
    logic [3:0] e_an;
    logic [3:0] e_hex;
    for (int j = 0; j < 16; j++) begin
      int d;
      #1;
      d     = j / 4;
      e_an  = ~(4'b0001 << d);
      e_hex = v[4*d +: 4];
      chk("frame hex", 16'(hex), 16'(e_hex));
      chk("frame dig_an", 16'(dig_an), 16'(e_an));
      chk("frame blank", 16'(blank), 16'(blank_mask[d]));
      chk("frame frame_done", 16'(frame_done), 16'(j == 0));
      @(negedge clk);
    end
    #1;
    chk("frame next pulse", 16'(frame_done), 16'h1);
    $display("frame of %04h checked at %0t", v, $time);
  endtask

  initial begin
    logic [3:0] nib1234 [4];
    nib1234 = '{4'h4, 4'h3, 4'h2, 4'h1};

    // Reset with no clock running.
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("reset");
    #1 clk_run = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Scan order: F,2,A,1 on digits 0..3.
    load_one(16'h1A2F);
    wait_boundary();
    check_frame(16'h1A2F, 4'b0000);

    // Tear-free load.
    load_one(16'h1234);
    wait_boundary();
    repeat (4) @(negedge clk);
    #1 chk("tear idx1 hex", 16'(hex), 16'h3);
    load_valid = 1'b1;
    load_data  = 16'hBEEF;
    @(negedge clk);
    load_data  = 16'h5678;
    for (int k = 53; k < 64; k++) begin
      #1;
      chk("tear ready low", 16'(load_ready), 16'h0);
      chk("tear old hex", 16'(hex), 16'(nib1234[(k / 4) % 4]));
      @(negedge clk);
    end
    #1 chk("tear ready back", 16'(load_ready), 16'h1);
    check_frame(16'hBEEF, 4'b0000);
    chk("second load applied", 16'(hex), 16'h8);
    load_valid = 1'b0;

    // Leading-zero suppression.
    load_one(16'h0030);
    wait_boundary();
    lz_en      = 1'b1;
    load_valid = 1'b1;
    load_data  = 16'h0000;
    check_frame(16'h0030, 4'b1100);
    load_valid = 1'b0;
    load_valid = 1'b1;
    load_data  = 16'h0030;
    check_frame(16'h0000, 4'b1110);
    load_valid = 1'b0;
    lz_en      = 1'b0;
    check_frame(16'h0030, 4'b0000);

    // Async reset with idx=2 and pending data.
    load_one(16'h9999);
    repeat (7) @(negedge clk);
    #1;
    chk("pre-reset dig_an", 16'(dig_an), 16'h000B);
    chk("pre-reset ready", 16'(load_ready), 16'h0);
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    wait_boundary();
    check_frame(16'h0000, 4'b0000);

    // Load offered exactly on the boundary edge.
    repeat (15) @(negedge clk);
    load_valid = 1'b1;
    load_data  = 16'hC0DE;
    #1 chk("boundary pre ready", 16'(load_ready), 16'h1);
    @(negedge clk);
    #1;
    chk("boundary pulse", 16'(frame_done), 16'h1);
    chk("boundary not applied", 16'(hex), 16'h0);
    chk("boundary accepted", 16'(load_ready), 16'h0);
    load_valid = 1'b0;
    check_frame(16'h0000, 4'b0000);
    chk("boundary applied later", 16'(hex), 16'hE);
    check_frame(16'hC0DE, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
